// File: rtl/clint_wb.sv
// rtl/clint_wb.sv - Wishbone B4 classic core-local interruptor (mtime, mtimecmp, msip).
// Optional CLINT_BUS_ERR_EN: unmapped offsets answer with wbs_err_o instead of wbs_ack_o.
module clint_wb #(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam logic [13:0] OFF_MSIP   = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI = 14'h1001;
  localparam logic [13:0] OFF_MT_LO  = 14'h2FFE;
  localparam logic [13:0] OFF_MT_HI  = 14'h2FFF;
  localparam logic [15:0] PRESC_MAX  = 16'(TICK_DIV - 32'd1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] presc;
  logic [13:0] off;
  logic        req;
  logic        wr;
  logic        tick;
  logic        mapped;
  logic [31:0] rd_data;
  logic [31:0] wmask;
  logic [31:0] mt_lo_new;
  logic [31:0] mt_hi_new;
  logic [31:0] cmp_lo_new;
  logic [31:0] cmp_hi_new;
  logic        unused_addr;

  // Only the word offset within the 64 KiB window is decoded.
  assign off         = wbs_addr_i[15:2];
  assign unused_addr = ^{wbs_addr_i[31:16], wbs_addr_i[1:0]};

  // The response strobe masks the request so every transfer takes exactly two cycles.
  assign req  = wbs_cyc_i & wbs_stb_i & ~(wbs_ack_o | wbs_err_o);
  assign wr   = req & wbs_we_i;
  assign tick = (presc == PRESC_MAX);

  assign wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign mt_lo_new  = (mtime[31:0]     & ~wmask) | (wbs_dat_i & wmask);
  assign mt_hi_new  = (mtime[63:32]    & ~wmask) | (wbs_dat_i & wmask);
  assign cmp_lo_new = (mtimecmp[31:0]  & ~wmask) | (wbs_dat_i & wmask);
  assign cmp_hi_new = (mtimecmp[63:32] & ~wmask) | (wbs_dat_i & wmask);

  assign xint_msip_o = msip;

  always_comb begin
    mapped  = 1'b1;
    rd_data = '0;
    case (off)
      OFF_MSIP:   rd_data = {31'b0, msip};
      OFF_CMP_LO: rd_data = mtimecmp[31:0];
      OFF_CMP_HI: rd_data = mtimecmp[63:32];
      OFF_MT_LO:  rd_data = mtime[31:0];
      OFF_MT_HI:  rd_data = mtime[63:32];
      default:    mapped  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime       <= '0;
      mtimecmp    <= MTIMECMP_RST;
      msip        <= 1'b0;
      presc       <= '0;
      xint_mtip_o <= 1'b0;
      wbs_dat_o   <= '0;
    end else begin
      presc       <= tick ? 16'd0 : presc + 16'd1;
      xint_mtip_o <= (mtime >= mtimecmp);
      // A bus write to either half wins over the tick; no carry between halves.
      if (wr && off == OFF_MT_LO)      mtime[31:0]  <= mt_lo_new;
      else if (wr && off == OFF_MT_HI) mtime[63:32] <= mt_hi_new;
      else if (tick)                   mtime        <= mtime + 64'd1;
      if (wr && off == OFF_CMP_LO) mtimecmp[31:0]  <= cmp_lo_new;
      if (wr && off == OFF_CMP_HI) mtimecmp[63:32] <= cmp_hi_new;
      if (wr && off == OFF_MSIP && wbs_sel_i[0]) msip <= wbs_dat_i[0];
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : 32'd0;
    end
  end

`ifdef CLINT_BUS_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
    end else begin
      wbs_ack_o <= req & mapped;
      wbs_err_o <= req & ~mapped;
    end
  end
`else
  logic unused_mapped;
  assign unused_mapped = mapped;
  assign wbs_err_o     = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wbs_ack_o <= 1'b0;
    else         wbs_ack_o <= req;
  end
`endif

endmodule

// File: tb/tb_clint_wb.sv
// tb/tb_clint_wb.sv - randomized self-checking bench for clint_wb against a behavioural model.
module tb_clint_wb;

  localparam int TDIV = 1;
`ifdef CLINT_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdat  = '0;
  logic [3:0]  sel   = '0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] dat, dat4;
  logic        ack, err, mtip, msip;
  logic        ack4, err4, mtip4, msip4;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: what the registers and outputs must hold after the latest edge.
  logic [63:0] m_mt, m_cmp;
  logic        m_msip, m_ack, m_err, m_mtip;
  logic [31:0] m_dat;
  int          m_cyc;

  always #5 clk = ~clk;

  clint_wb #(.TICK_DIV(TDIV), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat), .wbs_ack_o(ack),
    .wbs_err_o(err), .xint_mtip_o(mtip), .xint_msip_o(msip));

  clint_wb #(.TICK_DIV(4), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat4), .wbs_ack_o(ack4),
    .wbs_err_o(err4), .xint_mtip_o(mtip4), .xint_msip_o(msip4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mt   = 64'd0;
    m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_mtip = 1'b0;
    m_dat  = 32'd0;
    m_cyc  = 0;
  endtask

  // Advance the model by one rising edge using the bus inputs held across it.
  task automatic model_edge();
    logic        req, hit;
    logic [15:0] boff;
    logic [31:0] mask, rv;
    logic [63:0] nmt, ncmp;
    logic        nmsip, tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req  = cyc && stb && !(m_ack || m_err);
    boff = {addr[15:2], 2'b00};
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    hit  = 1'b1;
    rv   = 32'd0;
    case (boff)
      16'h0000: rv = {31'd0, m_msip};
      16'h4000: rv = m_cmp[31:0];
      16'h4004: rv = m_cmp[63:32];
      16'hBFF8: rv = m_mt[31:0];
      16'hBFFC: rv = m_mt[63:32];
      default:  hit = 1'b0;
    endcase
    tk    = ((m_cyc % TDIV) == TDIV - 1);
    nmt   = tk ? m_mt + 64'd1 : m_mt;
    ncmp  = m_cmp;
    nmsip = m_msip;
    if (req && we) begin
      case (boff)
        16'h0000: if (sel[0]) nmsip = wdat[0];
        16'h4000: ncmp[31:0]  = (m_cmp[31:0]  & ~mask) | (wdat & mask);
        16'h4004: ncmp[63:32] = (m_cmp[63:32] & ~mask) | (wdat & mask);
        16'hBFF8: nmt = {m_mt[63:32], (m_mt[31:0] & ~mask) | (wdat & mask)};
        16'hBFFC: nmt = {(m_mt[63:32] & ~mask) | (wdat & mask), m_mt[31:0]};
        default: ;
      endcase
    end
    m_mtip = (m_mt >= m_cmp);
    m_ack  = req && (hit || !ERR_EN);
    m_err  = req && !hit && ERR_EN;
    m_dat  = (req && !we) ? rv : 32'd0;
    m_mt   = nmt;
    m_cmp  = ncmp;
    m_msip = nmsip;
    m_cyc  = m_cyc + 1;
  endtask

  always @(negedge clk) begin
    check("ack", 64'(ack), 64'(m_ack));
    check("err", 64'(err), 64'(m_err));
    check("mtip", 64'(mtip), 64'(m_mtip));
    check("msip", 64'(msip), 64'(m_msip));
    check("ack_div4", 64'(ack4), 64'(m_ack));
    check("err_div4", 64'(err4), 64'(m_err));
    check("msip_div4", 64'(msip4), 64'(m_msip));
    if (m_ack) check("rdata", 64'(dat), 64'(m_dat));
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output logic [31:0] r4, output logic e);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack || err) && n < 4);
    if (!(ack || err)) check("bus_response", 64'(ack | err), 64'd1);
    r  = dat;
    r4 = dat4;
    e  = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r, r4;
    logic        e;
    bus(1'b1, a, d, s, r, r4, e);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output logic [31:0] r4);
    logic e;
    bus(1'b0, a, 32'd0, 4'hF, r, r4, e);
  endtask

  initial begin
    logic [31:0] r, r1, r2, q, qa, qb, rnd, a;
    logic        e;
    int          n;
    model_reset();
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat), 64'd0);
    check("rst_mtip_div4", 64'(mtip4), 64'd0);
    rst_n = 1'b1;

    repeat (10) tick();
    rd(32'h0000_BFF8, r, q);
    check("mtime_after_reset_in_range", 64'(r >= 32'd9 && r <= 32'd11), 64'd1);
    rd(32'h0000_4004, r, q);
    check("mtimecmp_hi_reset", 64'(r), 64'hFFFF_FFFF);
    check("mtip_after_reset", 64'(mtip), 64'd0);
    check("msip_after_reset", 64'(msip), 64'd0);

    wr(32'h0000_4004, 32'd0, 4'hF);
    wr(32'h0000_4000, 32'h40, 4'hF);
    n = 0;
    while (!mtip && n < 200) begin
      tick();
      n++;
    end
    check("mtip_rise", 64'(mtip), 64'd1);
    wr(32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
    check("mtip_fall", 64'(mtip), 64'd0);

    wr(32'h0000_BFF8, 32'hAABB_CCDD, 4'b0011);
    rd(32'h0000_BFF8, r, q);
    check("mtime_lo_byte_write", 64'(r), 64'h0000_CCDE);
    wr(32'h0000_BFFC, 32'd1, 4'hF);
    rd(32'h0000_BFFC, r, q);
    check("mtime_hi_write", 64'(r), 64'd1);
    rd(32'h0000_BFF8, r1, q);
    rd(32'h0000_BFF8, r2, q);
    check("mtime_lo_counting", 64'(r2 - r1), 64'd2);

    wr(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF);
    tick();
    rd(32'h0000_BFFC, r, q);
    check("wrap_hi", 64'(r), 64'd0);
    rd(32'h0000_BFF8, r, q);
    check("wrap_lo", 64'(r), 64'd2);

    wr(32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0000_0000, r, q);
    check("msip_readback", 64'(r), 64'd1);
    check("msip_set", 64'(msip), 64'd1);
    wr(32'h0000_0000, 32'd0, 4'h0);
    check("msip_sel0_kept", 64'(msip), 64'd1);
    wr(32'h0000_0000, 32'd0, 4'hF);
    check("msip_clear", 64'(msip), 64'd0);

    rd(32'h0000_BFF8, q, qa);
    repeat (98) tick();
    rd(32'h0000_BFF8, q, qb);
    check("div4_advance_100_cycles", 64'(qb - qa), 64'd25);

    bus(1'b0, 32'hABCD_1234, 32'd0, 4'hF, r, q, e);
`ifdef CLINT_BUS_ERR_EN
    check("unmapped_err", 64'(e), 64'd1);
`else
    check("unmapped_no_err", 64'(e), 64'd0);
    check("unmapped_data", 64'(r), 64'd0);
`endif

    repeat (3000) begin
      cyc  = ($urandom_range(0, 3) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1) == 1;
      wdat = $urandom;
      sel  = 4'($urandom_range(0, 15));
      rnd  = $urandom;
      case ($urandom_range(0, 5))
        0:       a = 32'h0000;
        1:       a = 32'h4000;
        2:       a = 32'h4004;
        3:       a = 32'hBFF8;
        4:       a = 32'hBFFC;
        default: a = $urandom;
      endcase
      addr = {rnd[31:16], a[15:2], rnd[1:0]};
      tick();
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    tick();

    wr(32'h0000_4004, 32'd0, 4'hF);
    wr(32'h0000_4000, 32'd0, 4'hF);
    wr(32'h0000_0000, 32'd1, 4'hF);
    tick();
    tick();
    check("pre_abort_mtip", 64'(mtip), 64'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0000_4000; wdat = 32'hFFFF_FFFF; sel = 4'hF;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_ack", 64'(ack), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_mtip", 64'(mtip), 64'd0);
    check("abort_msip", 64'(msip), 64'd0);
    check("abort_dat", 64'(dat), 64'd0);
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    rd(32'h0000_4000, r, q);
    check("abort_cmp_is_reset", 64'(r), 64'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
